if_stage: RTL
=============

# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC register, selects the next PC from the redirect source decided in ID, drives the instruction-memory address, and holds the IF/ID pipeline register. It sits directly upstream of the forwarding/hazard unit and consumes that unit's `stall` output. It also consumes the control-hazard flush, and produces the `ID_Instr` fields from which the hazard unit derives `ID_rs`, `ID_rt`, `ID_Op` and `ID_func`.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC loaded on reset.
- `clk`  in  1: pipeline clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `stall`  in  1: hazard-unit stall; freezes PC and IF/ID.
- `flush`  in  1: control hazard (`c_adventure`); squash the instruction currently being fetched.
- `PCSrc`  in  3: next-PC select from ID.
  - 000: PC+4.
  - 001: branch.
  - 010: j.
  - 011: jal.
  - 100: jr/jalr.
- `br_target`  in  32: branch target (ID_PC+4 + sext(imm)<<2).
- `j_target`  in  32: {ID_PC+4[31:28], instr_index, 2'b00}.
- `jr_target`  in  32: forwarded rs value.
- `imem_addr`  out  32: instruction-memory word address, equal to PC.
- `imem_rdata`  in  32: instruction, combinational read of `imem_addr`.
- `ID_Instr`  out  32: IF/ID instruction.
- `ID_PC`  out  32: IF/ID PC.
- `ID_PCplus4`  out  32: IF/ID PC+4.
- `ID_valid`  out  1: IF/ID holds a real instruction.

## Operation
- Reset values:
  - PC = `RESET_PC`.
  - `ID_Instr` = 32'h0 (nop).
  - `ID_PC` = 0, `ID_PCplus4` = 0.
  - `ID_valid` = 0.
  - FSM = BOOT.
- FSM states:
  - BOOT, one cycle after reset release: PC holds, IF/ID stays nop/invalid, then go to RUN.
  - RUN: normal operation.
  - Reset mid-operation returns to BOOT immediately (asynchronous).
- Next PC in RUN, priority stall > redirect > sequential:
  - `stall`=1: PC and the whole IF/ID register hold; `PCSrc` and `flush` are ignored that cycle.
  - `PCSrc`≠000: PC ← the selected target. Codes 101–111 are treated as 000.
  - Otherwise PC ← PC+4.
- IF/ID load when not stalled:
  - `flush`=1: `ID_Instr`←0, `ID_valid`←0, `ID_PC`/`ID_PCplus4` ← current PC/PC+4 (no delay slot).
  - Else: `ID_Instr`←`imem_rdata`, `ID_PC`←PC, `ID_PCplus4`←PC+4, `ID_valid`←1.
- `PCSrc`≠000 without `flush` is legal; the fetched instruction is kept. This is the ID stage's responsibility.
- Arithmetic:
  - PC+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0.
  - PC[1:0] is forced to 00 on every load, including `jr_target`.

## Timing
- PC register and IF/ID update on the rising edge of `clk`.
- `imem_addr` is combinational from PC.
- Fetch-to-ID latency is 1 cycle. Redirect latency is 1 cycle: the target appears on `imem_addr` in the cycle after `PCSrc` is sampled.
- A stall of N cycles holds all outputs for exactly N edges. The instruction fetched before the stall is not re-latched from memory; IF/ID retains it.
- `stall` and `flush` both high: hold wins, nothing squashed. The hazard unit re-asserts `flush` once the stall clears.
- First valid `ID_Instr` (from `RESET_PC`) appears 2 edges after `rst` falls.

## Configuration
- `IF_PERF_CNT_EN` defined adds three 32-bit outputs, `perf_fetch`, `perf_stall` and `perf_flush`.
  - They count, respectively: RUN cycles with a valid fetch, stall cycles, and flush cycles.
  - All three reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package `pipe_pkg`:
  - `PCSrc` encodings `PCSRC_SEQ`, `PCSRC_BR`, `PCSRC_J`, `PCSRC_JAL`, `PCSRC_JR`.
  - `NOP_INSTR` = 32'h0.
  - Default `RESET_PC`.
- Sub-module `if_id_reg`: a holdable, flushable IF/ID register with async reset. The PC mux, FSM and counters stay in `if_stage`.

## Test plan
- Reset release, no stall: `imem_addr`=3000 for 2 cycles, then 3004. `ID_Instr` = mem[3000] with `ID_valid`=1 on edge 2.
- `stall` high 3 cycles at PC=3008: `imem_addr` stays 3008 and `ID_Instr` holds mem[3004] for 3 edges; next edge gives mem[3008].
- `PCSrc`=001, `br_target`=3040, `flush`=1 at PC=300C: next cycle `imem_addr`=3040, `ID_Instr`=0, `ID_valid`=0; following edge gives mem[3040].
- `PCSrc`=100, `jr_target`=32'h0000_3023: PC becomes 3020 (low bits cleared).
- `stall`=1, `flush`=1, `PCSrc`=010 simultaneously: PC and IF/ID unchanged. With `IF_PERF_CNT_EN`, `perf_stall` +1 and `perf_flush` +0.
- `rst` pulsed mid-run at PC=3100: outputs return to reset values asynchronously, then the BOOT sequence restarts from 3000.

Source files
------------

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the 5-stage MIPS pipeline.
//   - PCSrc encodings used by ID to steer the next-PC mux in IF
//   - NOP instruction word used to squash pipeline registers
//   - Default reset PC
//   - Fetch-stage FSM state type
//   - Helper to force word alignment of any PC value
// -----------------------------------------------------------------------------
package pipe_pkg;

   // Next-PC select codes driven by the ID stage.
   // Codes 101-111 are unused and fall back to sequential fetch.
   localparam logic [2:0] PCSRC_SEQ = 3'b000;
   localparam logic [2:0] PCSRC_BR  = 3'b001;
   localparam logic [2:0] PCSRC_J   = 3'b010;
   localparam logic [2:0] PCSRC_JAL = 3'b011;
   localparam logic [2:0] PCSRC_JR  = 3'b100;

   // All-zero word is sll $0,$0,0, which is a MIPS nop.
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   // Where fetch begins after reset.
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

   // BOOT gives the memory system one quiet cycle after reset release
   // before the first real fetch is latched into IF/ID.
   typedef enum logic {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } if_state_e;

   // Instruction addresses are always word aligned; a misaligned jr
   // target is silently rounded down rather than trapping.
   function automatic logic [31:0] alignPc(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register: holdable, flushable, asynchronously reset.
//
// Ports
//   clk        in   pipeline clock, rising edge
//   rst        in   asynchronous active-high reset
//   load_i     in   1 = capture new contents this edge, 0 = hold
//   flush_i    in   when loading, replace the instruction with a nop and
//                   mark the slot invalid (PC fields still captured)
//   instr_i    in   instruction fetched this cycle
//   pc_i       in   PC of that instruction
//   pcPlus4_i  in   PC+4 of that instruction
//   instr_o    out  registered instruction
//   pc_o       out  registered PC
//   pcPlus4_o  out  registered PC+4
//   valid_o    out  registered slot holds a real instruction
// -----------------------------------------------------------------------------
module if_id_reg
   import pipe_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic        flush_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] pcPlus4_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic [31:0] pcPlus4_o,
   output logic        valid_o
);

   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pcPlus4_q, pcPlus4_d;
   logic        valid_q, valid_d;

   // Next-state selection. Holding is the default so that a stall keeps
   // the instruction already in ID instead of re-reading memory. A flush
   // squashes only the instruction and valid bit; the PC fields are still
   // captured so that ID sees where the squashed slot came from.
   always_comb begin
      instr_d   = instr_q;
      pc_d      = pc_q;
      pcPlus4_d = pcPlus4_q;
      valid_d   = valid_q;
      if (load_i) begin
         pc_d      = pc_i;
         pcPlus4_d = pcPlus4_i;
         if (flush_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
         end else begin
            instr_d = instr_i;
            valid_d = 1'b1;
         end
      end
   end

   // Register bank. Reset presents a nop with zeroed PC fields so the
   // downstream stages see an empty slot until the first real fetch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_q   <= NOP_INSTR;
         pc_q      <= 32'h0;
         pcPlus4_q <= 32'h0;
         valid_q   <= 1'b0;
      end else begin
         instr_q   <= instr_d;
         pc_q      <= pc_d;
         pcPlus4_q <= pcPlus4_d;
         valid_q   <= valid_d;
      end
   end

   assign instr_o   = instr_q;
   assign pc_o      = pc_q;
   assign pcPlus4_o = pcPlus4_q;
   assign valid_o   = valid_q;

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC, picks
// the next PC from the redirect source decided in ID, drives the
// instruction-memory address and holds the IF/ID register (if_id_reg).
//
// Parameters
//   RESET_PC     PC loaded on reset (default 32'h0000_3000)
//
// Ports
//   clk          in   pipeline clock, rising edge
//   rst          in   asynchronous active-high reset
//   stall        in   hazard-unit stall: freezes PC and IF/ID
//   flush        in   control hazard: squash the instruction being fetched
//   PCSrc        in   next-PC select (SEQ/BR/J/JAL/JR, others = SEQ)
//   br_target    in   branch target
//   j_target     in   j/jal target
//   jr_target    in   jr/jalr target (forwarded rs)
//   imem_addr    out  instruction-memory address (= PC)
//   imem_rdata   in   instruction at imem_addr (combinational read)
//   ID_Instr     out  IF/ID instruction
//   ID_PC        out  IF/ID PC
//   ID_PCplus4   out  IF/ID PC+4
//   ID_valid     out  IF/ID holds a real instruction
//
// Optional feature, macro IF_PERF_CNT_EN:
//   perf_fetch   out  RUN cycles that latched a valid fetch
//   perf_stall   out  RUN cycles with stall asserted
//   perf_flush   out  RUN cycles that squashed a fetch
//   All three saturate at 32'hFFFF_FFFF. Without the macro these ports and
//   counters do not exist.
// -----------------------------------------------------------------------------
module if_stage
   import pipe_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic [2:0]  PCSrc,
   input  logic [31:0] br_target,
   input  logic [31:0] j_target,
   input  logic [31:0] jr_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ID_Instr,
   output logic [31:0] ID_PC,
   output logic [31:0] ID_PCplus4,
   output logic        ID_valid
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetch,
   output logic [31:0] perf_stall,
   output logic [31:0] perf_flush
`endif
);

   if_state_e   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pcPlus4;
   logic        inRun;
   logic        advance;

   // Sequential successor; wraps modulo 2^32 on its own.
   assign pcPlus4 = pc_q + 32'd4;

   // Fetch only advances in RUN and when the hazard unit is not holding us.
   // While stalled, PCSrc and flush are deliberately ignored: the hazard
   // unit re-issues them once the stall drops.
   assign inRun   = (state_q == ST_RUN);
   assign advance = inRun && !stall;

   // FSM next-state: BOOT lasts exactly one cycle after reset release.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_BOOT;
      endcase
   end

   // Next-PC mux. Redirects beat sequential fetch; unused PCSrc codes
   // behave like sequential. Every loaded value is word aligned so a
   // misaligned jr target cannot leave the PC pointing mid-word.
   always_comb begin
      pc_d = pc_q;
      if (advance) begin
         case (PCSrc)
            PCSRC_BR:  pc_d = alignPc(br_target);
            PCSRC_J:   pc_d = alignPc(j_target);
            PCSRC_JAL: pc_d = alignPc(j_target);
            PCSRC_JR:  pc_d = alignPc(jr_target);
            default:   pc_d = alignPc(pcPlus4);
         endcase
      end
   end

   // State and PC registers. Asynchronous reset drops straight back to
   // BOOT at the reset address, even mid-run.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_BOOT;
         pc_q    <= alignPc(RESET_PC);
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   assign imem_addr = pc_q;

   // IF/ID register: loads on the same cycles the PC advances, so a stall
   // freezes both sides together and BOOT leaves IF/ID as an empty nop.
   if_id_reg u_if_id_reg (
      .clk       (clk),
      .rst       (rst),
      .load_i    (advance),
      .flush_i   (flush),
      .instr_i   (imem_rdata),
      .pc_i      (pc_q),
      .pcPlus4_i (pcPlus4),
      .instr_o   (ID_Instr),
      .pc_o      (ID_PC),
      .pcPlus4_o (ID_PCplus4),
      .valid_o   (ID_valid)
   );

`ifdef IF_PERF_CNT_EN
   logic [31:0] perfFetch_q, perfFetch_d;
   logic [31:0] perfStall_q, perfStall_d;
   logic [31:0] perfFlush_q, perfFlush_d;

   // Event counters. A stall cycle counts as a stall even if flush is
   // also high, because nothing is squashed in that cycle. Each counter
   // sticks at all-ones instead of wrapping.
   always_comb begin
      perfFetch_d = perfFetch_q;
      perfStall_d = perfStall_q;
      perfFlush_d = perfFlush_q;
      if (inRun) begin
         if (stall) begin
            if (perfStall_q != 32'hFFFF_FFFF) perfStall_d = perfStall_q + 32'd1;
         end else if (flush) begin
            if (perfFlush_q != 32'hFFFF_FFFF) perfFlush_d = perfFlush_q + 32'd1;
         end else begin
            if (perfFetch_q != 32'hFFFF_FFFF) perfFetch_d = perfFetch_q + 32'd1;
         end
      end
   end

   // Counter registers, cleared on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perfFetch_q <= 32'h0;
         perfStall_q <= 32'h0;
         perfFlush_q <= 32'h0;
      end else begin
         perfFetch_q <= perfFetch_d;
         perfStall_q <= perfStall_d;
         perfFlush_q <= perfFlush_d;
      end
   end

   assign perf_fetch = perfFetch_q;
   assign perf_stall = perfStall_q;
   assign perf_flush = perfFlush_q;
`endif

endmodule
